// File: rtl/upd_page_reader_pkg.sv
// ============================================================================
// Module : upd_page_reader_pkg
// Brief  : Shared constants, FSM encoding and helpers for the page reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package upd_page_reader_pkg;

  localparam int UPD_PAGE_WORDS = 64;
  localparam int UPD_ADDR_W     = 6;
  localparam int UPD_CNT_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } upd_state_e;

  // Zero (and anything past a full page) means a full page, so the address never wraps.
  function automatic logic [UPD_CNT_W-1:0] upd_norm_count(input logic [UPD_CNT_W-1:0] cnt);
    if ((cnt == '0) || (cnt > UPD_CNT_W'(UPD_PAGE_WORDS))) begin
      return UPD_CNT_W'(UPD_PAGE_WORDS);
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/upd_page_reader_if.sv
// ============================================================================
// Module : upd_page_reader_if
// Brief  : Command, RAM read port and byte stream bundle of the page reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface upd_page_reader_if;
  import upd_page_reader_pkg::*;

  logic                  start;
  logic [UPD_CNT_W-1:0]  word_cnt;
  logic                  busy;
  logic                  done;
  logic [UPD_ADDR_W-1:0] rdaddress;
  logic [31:0]           q;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  byte_last;
  logic [15:0]           csum;

  modport slave (
    input  start, word_cnt, q, byte_ready,
    output busy, done, rdaddress, byte_data, byte_valid, byte_last, csum
  );

  modport master (
    output start, word_cnt, q, byte_ready,
    input  busy, done, rdaddress, byte_data, byte_valid, byte_last, csum
  );

endinterface

`default_nettype wire

// File: rtl/upd_page_reader_serializer.sv
// ============================================================================
// Module : upd_word_serializer
// Brief  : Turns one 32-bit word into four handshaken bytes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module upd_word_serializer #(
  parameter bit BYTE_MSB_FIRST = 1'b1
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic        load_i,
  input  wire logic [31:0] word_i,
  input  wire logic        ready_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             word_done_o
);

  logic [31:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [7:0]  w_cur_byte;
  logic [31:0] w_sh_next;

  generate
    if (BYTE_MSB_FIRST) begin : g_msb_first
      assign w_cur_byte = sh_q[31:24];
      assign w_sh_next  = {sh_q[23:0], 8'h00};
    end else begin : g_lsb_first
      assign w_cur_byte = sh_q[7:0];
      assign w_sh_next  = {8'h00, sh_q[31:8]};
    end
  endgenerate

  // The last byte is not shifted out so data stays put once valid drops.
  always_comb begin
    sh_d    = sh_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      sh_d    = word_i;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      if (idx_q == 2'd3) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
        sh_d  = w_sh_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign data_o      = w_cur_byte;
  assign valid_o     = valid_q;
  assign last_o      = valid_q && (idx_q == 2'd3);
  assign word_done_o = valid_q && ready_i && (idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/upd_page_reader.sv
// ============================================================================
// Module : upd_page_reader
// Brief  : Reads a firmware-update page from RAM and streams it as bytes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module upd_page_reader
  import upd_page_reader_pkg::*;
#(
  parameter int RD_LAT         = 2,
  parameter bit BYTE_MSB_FIRST = 1'b1
) (
  input  wire logic       sys_clk,
  input  wire logic       sys_rst_n,
  upd_page_reader_if.slave bus
);

  // FETCH spans RD_LAT+1 cycles: one to launch the address, RD_LAT for the RAM.
  localparam logic [3:0] WAIT_LAST = 4'(RD_LAT);

  upd_state_e            state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [UPD_ADDR_W-1:0] addr_q, addr_d;
  logic [UPD_CNT_W-1:0]  rem_q, rem_d;
  logic [15:0]           csum_q, csum_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  w_load;
  logic [7:0]            w_ser_data;
  logic                  w_ser_valid;
  logic                  w_ser_last;
  logic                  w_word_done;
  logic                  w_hs;

  upd_word_serializer #(
    .BYTE_MSB_FIRST (BYTE_MSB_FIRST)
  ) u_ser (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .load_i      (w_load),
    .word_i      (bus.q),
    .ready_i     (bus.byte_ready),
    .data_o      (w_ser_data),
    .valid_o     (w_ser_valid),
    .last_o      (w_ser_last),
    .word_done_o (w_word_done)
  );

  assign w_hs = w_ser_valid && bus.byte_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    w_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rem_d   = upd_norm_count(bus.word_cnt);
          addr_d  = '0;
          csum_d  = '0;
          wait_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          w_load  = 1'b1;
          wait_d  = '0;
          state_d = ST_SEND;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          csum_d = csum_q + {8'h00, w_ser_data};
        end
        if (w_word_done) begin
          if (rem_q > UPD_CNT_W'(1)) begin
            rem_d   = rem_q - UPD_CNT_W'(1);
            addr_d  = addr_q + UPD_ADDR_W'(1);
            state_d = ST_FETCH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rdaddress  = addr_q;
  assign bus.byte_data  = w_ser_data;
  assign bus.byte_valid = w_ser_valid;
  assign bus.byte_last  = w_ser_last && (rem_q == UPD_CNT_W'(1));
  assign bus.csum       = csum_q;

endmodule

`default_nettype wire

// File: tb/tb_upd_page_reader.sv
// ============================================================================
// Module : tb_upd_page_reader
// Brief  : Directed self-checking bench for upd_page_reader (two configurations).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_upd_page_reader;
  import upd_page_reader_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  upd_page_reader_if bus_a ();
  upd_page_reader_if bus_b ();

  upd_page_reader #(.RD_LAT(2), .BYTE_MSB_FIRST(1'b1)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_a)
  );

  upd_page_reader #(.RD_LAT(1), .BYTE_MSB_FIRST(1'b0)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_b)
  );

  // RAM models: two-stage pipeline for registered output, one stage otherwise.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] qa_p1, qa_p2, qb_p1;
  always @(posedge clk) begin
    qa_p1 <= mem_a[bus_a.rdaddress];
    qa_p2 <= qa_p1;
    qb_p1 <= mem_b[bus_b.rdaddress];
  end
  assign bus_a.q = qa_p2;
  assign bus_b.q = qb_p1;

  int tests = 0;
  int fails = 0;
  int cycle_n = 0;

  logic [7:0] qa [$];
  bit         la [$];
  int         ta [$];
  logic [7:0] qb [$];
  int         tbh [$];
  int         done_a, done_b, done_cyc_a, busy_falls, stall_viol, stalls;
  logic [5:0] addr_max;
  bit         seen_nz, wrapped, prev_busy, prev_stall, ready_rand;
  logic [7:0] prev_data;

  logic [7:0] exp_b [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_a(input int i);
    return 8'((i / 4) + (i % 4));
  endfunction

  task automatic clear_mon();
    qa.delete(); la.delete(); ta.delete(); qb.delete(); tbh.delete();
    done_a = 0; done_b = 0; done_cyc_a = -1; busy_falls = 0;
    stall_viol = 0; stalls = 0; addr_max = '0; seen_nz = 0; wrapped = 0;
    prev_busy = 0; prev_stall = 0; prev_data = '0;
  endtask

  // One clock: set ready, then observe what the next edge will do.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle_n++;
    bus_a.byte_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (prev_stall && !(bus_a.byte_valid && (bus_a.byte_data == prev_data))) stall_viol++;
    if (bus_a.byte_valid && bus_a.byte_ready) begin
      qa.push_back(bus_a.byte_data);
      la.push_back(bus_a.byte_last);
      ta.push_back(cycle_n);
    end
    prev_stall = bus_a.byte_valid && !bus_a.byte_ready;
    prev_data  = bus_a.byte_data;
    if (prev_stall) stalls++;
    if (bus_a.done) begin
      done_a++;
      done_cyc_a = cycle_n;
    end
    if (prev_busy && !bus_a.busy) busy_falls++;
    prev_busy = bus_a.busy;
    if (bus_a.busy) begin
      if (bus_a.rdaddress > addr_max) addr_max = bus_a.rdaddress;
      if (bus_a.rdaddress != 6'd0) seen_nz = 1;
      else if (seen_nz) wrapped = 1;
    end
    if (bus_b.byte_valid && bus_b.byte_ready) begin
      qb.push_back(bus_b.byte_data);
      tbh.push_back(cycle_n);
    end
    if (bus_b.done) done_b++;
  endtask

  task automatic start_a(input logic [6:0] n);
    bus_a.word_cnt = n;
    bus_a.start    = 1'b1;
    cyc();
    bus_a.start    = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while ((bus_a.done !== 1'b1) && (n < budget)) begin
      cyc();
      n++;
    end
    check(tag, 32'(bus_a.done), 32'd1);
  endtask

  task automatic check_stream_a(input string tag, input int nbytes);
    int mism = 0;
    int lastcnt = 0;
    int lastidx = -1;
    check({tag, "_nbytes"}, 32'(qa.size()), 32'(nbytes));
    foreach (qa[i]) begin
      if (qa[i] !== exp_a(i)) mism++;
      if (la[i]) begin
        lastcnt++;
        lastidx = i;
      end
    end
    check({tag, "_bytes"}, 32'(mism), 32'd0);
    check({tag, "_last_cnt"}, 32'(lastcnt), 32'd1);
    check({tag, "_last_pos"}, 32'(lastidx), 32'(nbytes - 1));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
      mem_b[i] = 32'h0;
    end
    mem_b[0] = 32'h11223344;
    mem_b[1] = 32'h55667788;

    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.word_cnt = '0; bus_a.byte_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.word_cnt = '0; bus_b.byte_ready = 1'b1;
    ready_rand = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(bus_a.busy), 32'd0);
    check("rst_done",  32'(bus_a.done), 32'd0);
    check("rst_addr",  32'(bus_a.rdaddress), 32'd0);
    check("rst_data",  32'(bus_a.byte_data), 32'd0);
    check("rst_valid", 32'(bus_a.byte_valid), 32'd0);
    check("rst_last",  32'(bus_a.byte_last), 32'd0);
    check("rst_csum",  32'(bus_a.csum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    clear_mon();

    // Two-word page, no backpressure.
    start_a(7'd2);
    check("t1_busy", 32'(bus_a.busy), 32'd1);
    wait_done_a("t1_done_seen", 200);
    check_stream_a("t1", 8);
    if (ta.size() >= 8) begin
      check("t1_gap", 32'(ta[4] - ta[3]), 32'd4);
      check("t1_done_lat", 32'(done_cyc_a - ta[7]), 32'd1);
    end else begin
      check("t1_hs_count", 32'(ta.size()), 32'd8);
    end
    check("t1_csum", 32'(bus_a.csum), 32'h0010);
    check("t1_busy_at_done", 32'(bus_a.busy), 32'd0);
    cyc();
    check("t1_done_pulse", 32'(bus_a.done), 32'd0);
    check("t1_done_cnt", 32'(done_a), 32'd1);
    check("t1_addr_hold", 32'(bus_a.rdaddress), 32'd1);

    // Full page via word_cnt=0.
    clear_mon();
    start_a(7'd0);
    wait_done_a("t2_done_seen", 3000);
    check_stream_a("t2", 256);
    check("t2_addr_max", 32'(addr_max), 32'd63);
    check("t2_no_wrap", 32'(wrapped), 32'd0);
    check("t2_csum", 32'(bus_a.csum), 32'h2100);
    repeat (4) cyc();
    check("t2_addr_hold", 32'(bus_a.rdaddress), 32'd63);
    check("t2_csum_hold", 32'(bus_a.csum), 32'h2100);
    check("t2_done_cnt", 32'(done_a), 32'd1);

    // Four-word page with random backpressure.
    clear_mon();
    ready_rand = 1;
    start_a(7'd4);
    wait_done_a("t3_done_seen", 1000);
    ready_rand = 0;
    bus_a.byte_ready = 1'b1;
    check_stream_a("t3", 16);
    check("t3_stable", 32'(stall_viol), 32'd0);
    check("t3_csum", 32'(bus_a.csum), 32'h0030);
    cyc();

    // start while busy and coincident with done is ignored.
    clear_mon();
    start_a(7'd2);
    repeat (5) cyc();
    bus_a.word_cnt = 7'd5;
    bus_a.start    = 1'b1;
    cyc();
    bus_a.start    = 1'b0;
    wait_done_a("t4_done_seen", 200);
    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    repeat (10) cyc();
    check("t4_done_cnt", 32'(done_a), 32'd1);
    check("t4_busy_falls", 32'(busy_falls), 32'd1);
    check("t4_nbytes", 32'(qa.size()), 32'd8);
    check("t4_busy_idle", 32'(bus_a.busy), 32'd0);
    check("t4_csum", 32'(bus_a.csum), 32'h0010);
    check("t4_addr", 32'(bus_a.rdaddress), 32'd1);

    // Reset in the middle of a page.
    clear_mon();
    start_a(7'd2);
    for (int n = 0; (n < 100) && (qa.size() < 5); n++) cyc();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy",  32'(bus_a.busy), 32'd0);
    check("t5_rst_valid", 32'(bus_a.byte_valid), 32'd0);
    check("t5_rst_data",  32'(bus_a.byte_data), 32'd0);
    check("t5_rst_last",  32'(bus_a.byte_last), 32'd0);
    check("t5_rst_csum",  32'(bus_a.csum), 32'd0);
    check("t5_rst_addr",  32'(bus_a.rdaddress), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_rst_no_done", 32'(bus_a.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    clear_mon();
    start_a(7'd1);
    wait_done_a("t5_done_seen", 100);
    check_stream_a("t5", 4);
    check("t5_csum", 32'(bus_a.csum), 32'h0006);
    cyc();

    // LSB-first, RD_LAT=1 instance.
    clear_mon();
    bus_b.word_cnt = 7'd2;
    bus_b.start    = 1'b1;
    cyc();
    bus_b.start    = 1'b0;
    for (int n = 0; (n < 200) && (bus_b.done !== 1'b1); n++) cyc();
    check("t6_done_seen", 32'(bus_b.done), 32'd1);
    check("t6_nbytes", 32'(qb.size()), 32'd8);
    begin
      int mism = 0;
      foreach (qb[i]) if ((i < 8) && (qb[i] !== exp_b[i])) mism++;
      check("t6_bytes", 32'(mism), 32'd0);
    end
    if (tbh.size() >= 5) check("t6_gap", 32'(tbh[4] - tbh[3]), 32'd3);
    else                 check("t6_hs_count", 32'(tbh.size()), 32'd8);
    check("t6_csum", 32'(bus_b.csum), 32'h0264);
    cyc();
    check("t6_done_cnt", 32'(done_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/upd_page_reader.md
Name: upd_page_reader

Overview:
- Read-side controller for the 32-bit x 64-word firmware-update page buffer (dual-port RAM, 6-bit address).
- On a start command, fetches N words from the RAM read port and serialises them into a byte stream with valid/ready handshake toward the flash programming engine.
- Keeps a running 16-bit byte checksum of the page for update verification.
- Runs entirely in the RAM read-clock domain.

Parameters:
- RD_LAT, 2, RAM read latency in cycles from rdaddress to valid q (1 = unregistered output, 2 = registered output).
- BYTE_MSB_FIRST, 1, 1 = emit q[31:24] first; 0 = emit q[7:0] first.

Ports:
- sys_clk  in  1  single clock, RAM read clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; ignored unless idle.
- word_cnt  in  7  words to read, 1..64; sampled on accepted start; 0 is treated as 64.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last byte handshake.
- rdaddress  out  6  RAM read address.
- q  in  32  RAM read data.
- byte_data  out  8  stream data.
- byte_valid  out  1  stream valid.
- byte_ready  in  1  stream ready from downstream.
- byte_last  out  1  high with the final byte of the page.
- csum  out  16  sum mod 2^16 of all bytes handshaken in the current/last page.

Behaviour:
- Reset values: busy=0, done=0, rdaddress=0, byte_data=0, byte_valid=0, byte_last=0, csum=0. The FSM resets to IDLE.
- Reset asserted mid-page aborts immediately. No done pulse is generated and the stream drops valid.
- FSM states:
  - IDLE: on start, latch count (0 maps to 64), set rdaddress=0, clear csum, busy=1, go to FETCH.
  - FETCH: hold rdaddress for RD_LAT cycles using a wait counter. On the final wait cycle, capture q into a 32-bit shift register. Go to SEND with byte index 0.
  - SEND: byte_valid=1 and byte_data = current byte per BYTE_MSB_FIRST.
    - On byte_valid && byte_ready: add byte_data to csum and advance the byte index.
    - After byte index 3 is handshaken: if words remain, increment rdaddress and go to FETCH; otherwise go to DONE.
  - DONE: pulse done=1 for one cycle, busy=0, return to IDLE.
- byte_data and byte_valid are registered. Both stay stable while byte_valid && !byte_ready (no drop, no change).
- byte_last = 1 only on byte index 3 of the final word.
- start during busy is ignored, including start coincident with done.
- Throughput: one byte per cycle within a word. Each word boundary inserts RD_LAT+1 idle cycles (valid low).
- Address wrap: with word_cnt=64 the last address is 63. rdaddress never wraps to 0 within a page. After done it holds 63 until the next start.
- csum width rule: an 8-bit zero-extended add into 16 bits, with carry out of bit 15 discarded. csum holds its value after done until the next accepted start.

Decomposition:
- Shared update package holds:
  - constants UPD_PAGE_WORDS=64 and UPD_ADDR_W=6;
  - the FSM state encoding (IDLE, FETCH, SEND, DONE).
- One natural sub-module: upd_word_serializer. It takes a 32-bit load plus valid/ready and emits 4 bytes with last-of-word, byte order per BYTE_MSB_FIRST.
- The top level keeps the FSM, address/word counters and checksum.

Test Plan:
- RAM preloaded with word i = {i,i+1,i+2,i+3} bytes. start with word_cnt=2, ready tied 1, RD_LAT=2 -> bytes 00 01 02 03 01 02 03 04 in order; byte_last on 8th byte; done one cycle later; csum=0x0010.
- word_cnt=0 -> 256 bytes from addresses 0..63; rdaddress peaks at 63 and never returns to 0 mid-page; done exactly once.
- Random byte_ready backpressure (50%) on a 4-word page -> byte_data/byte_valid stable while stalled; byte sequence and csum identical to the no-stall run.
- start pulsed again mid-page and in the same cycle as done -> ignored; single done; busy falls only once.
- sys_rst_n asserted while in SEND after 5 bytes, then released and start re-issued with word_cnt=1 -> all outputs reset immediately; new page emits 4 correct bytes; csum covers only the new page.
- BYTE_MSB_FIRST=0, RD_LAT=1, word 0x11223344 -> bytes 44 33 22 11; inter-word gap is 2 idle cycles.
